// File: rtl/eq_pkg.sv
// Shared widths and constants for the feed-forward equalizer and its slicer.
// Optional feature macro: FFE_ERR_SAT_EN (saturating error output, see slicer_err).
package eq_pkg;

  // Sample and coefficient formats are both S(9,7)
  localparam int unsigned DATA_BW     = 9;
  localparam int unsigned COEF_BW     = 9;
  localparam int unsigned N_COEF      = 7;

  // Full-precision product S(18,14); the sum gains log2 headroom for the tap count
  localparam int unsigned PROD_BW     = DATA_BW + COEF_BW;
  localparam int unsigned SUM_BW      = PROD_BW + $clog2(N_COEF);

  // Error is formed one bit wider than the sum, then floored to 2^-7 resolution
  localparam int unsigned ERR_FULL_BW = SUM_BW + 1;
  localparam int unsigned ERR_BW      = 8;
  localparam int unsigned ERR_SHIFT   = 7;

  // Decision level +/-0.5 at 2^-14 resolution
  localparam int          DEC_LEVEL   = 8192;

endpackage

// File: rtl/slicer_err.sv
// Binary slicer plus decision-error generator (purely combinational).
// Macro FFE_ERR_SAT_EN: clamp the 8-bit error instead of wrapping it.
module slicer_err
  import eq_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_BW
) (
  input  logic signed [SUM_W-1:0]  i_sum,
  output logic                     o_symbol,
  output logic signed [ERR_BW-1:0] o_error
);

  localparam int unsigned FULL_W = SUM_W + 1;

  logic signed [FULL_W-1:0] dec;
  logic signed [FULL_W-1:0] err_full;
`ifdef FFE_ERR_SAT_EN
  localparam logic signed [FULL_W-1:0] ErrMax = FULL_W'(2 ** (ERR_BW - 1) - 1);
  localparam logic signed [FULL_W-1:0] ErrMin = -FULL_W'(2 ** (ERR_BW - 1));
  logic signed [FULL_W-1:0] err_trunc;
`else
  logic signed [ERR_BW-1:0] err_trunc;
`endif

  // Decide the symbol, form d - sum, floor to 2^-7 and narrow to 8 bits
  always_comb begin
    o_symbol = ~i_sum[SUM_W-1];
    dec      = o_symbol ? FULL_W'(DEC_LEVEL) : -FULL_W'(DEC_LEVEL);
    err_full = dec - FULL_W'(i_sum);
`ifdef FFE_ERR_SAT_EN
    err_trunc = err_full >>> ERR_SHIFT;
    if (err_trunc > ErrMax) begin
      o_error = {1'b0, {(ERR_BW - 1){1'b1}}};
    end else if (err_trunc < ErrMin) begin
      o_error = {1'b1, {(ERR_BW - 1){1'b0}}};
    end else begin
      o_error = err_trunc[ERR_BW-1:0];
    end
`else
    // Arithmetic shift floors; keeping the low bits gives two's-complement wrap
    err_trunc = ERR_BW'(err_full >>> ERR_SHIFT);
    o_error   = err_trunc;
`endif
  end

endmodule

// File: rtl/ffe_slicer.sv
// Seven-tap FIR feed-forward equalizer with binary slicer and LMS error output.
// Pipeline: delay-line load -> registered products -> registered sum/decision/error.
// Macro FFE_ERR_SAT_EN selects a saturating (instead of wrapping) error output.
module ffe_slicer
  import eq_pkg::ERR_BW;
#(
  parameter int unsigned DATA_BW = eq_pkg::DATA_BW,
  parameter int unsigned COEF_BW = eq_pkg::COEF_BW,
  parameter int unsigned N_COEF  = eq_pkg::N_COEF
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_valid,
  input  logic signed [DATA_BW-1:0]                i_data,
  input  logic        [COEF_BW*N_COEF-1:0]         i_coefs,
  output logic                                     o_valid,
  output logic signed [DATA_BW+COEF_BW+$clog2(N_COEF)-1:0] o_y,
  output logic                                     o_symbol,
  output logic signed [ERR_BW-1:0]                 o_error
);

  localparam int unsigned PROD_W = DATA_BW + COEF_BW;
  localparam int unsigned SUM_W  = PROD_W + $clog2(N_COEF);

  logic signed [DATA_BW-1:0] x_q    [N_COEF];
  logic signed [COEF_BW-1:0] coef   [N_COEF];
  logic signed [PROD_W-1:0]  prod_d [N_COEF];
  logic signed [PROD_W-1:0]  prod_q [N_COEF];
  logic signed [SUM_W-1:0]   sum_d;
  logic                      vld_x_q;
  logic                      vld_p_q;
  logic                      valid_q;
  logic signed [SUM_W-1:0]   y_q;
  logic                      symbol_q;
  logic signed [ERR_BW-1:0]  error_q;
  logic                      symbol_d;
  logic signed [ERR_BW-1:0]  error_d;

  // Tap delay line: shift in one sample per accepted valid, hold otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < N_COEF; k++) x_q[k] <= '0;
    end else if (i_valid) begin
      x_q[0] <= i_data;
      for (int unsigned k = 1; k < N_COEF; k++) x_q[k] <= x_q[k-1];
    end
  end

  // Unpack taps and form full-precision products against the live coefficients
  always_comb begin
    for (int unsigned k = 0; k < N_COEF; k++) begin
      coef[k]   = $signed(i_coefs[COEF_BW*k +: COEF_BW]);
      prod_d[k] = PROD_W'(x_q[k]) * PROD_W'(coef[k]);
    end
  end

  // Stage 1: register products on the edge after a delay-line load
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < N_COEF; k++) prod_q[k] <= '0;
    end else if (vld_x_q) begin
      for (int unsigned k = 0; k < N_COEF; k++) prod_q[k] <= prod_d[k];
    end
  end

  // Adder tree; headroom bits make overflow impossible
  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < N_COEF; k++) sum_d = sum_d + SUM_W'(prod_q[k]);
  end

  slicer_err #(
    .SUM_W (SUM_W)
  ) u_slicer_err (
    .i_sum    (sum_d),
    .o_symbol (symbol_d),
    .o_error  (error_d)
  );

  // Stage 2: register sum, decision and error only for a valid product set
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      y_q      <= '0;
      symbol_q <= 1'b0;
      error_q  <= '0;
    end else if (vld_p_q) begin
      y_q      <= sum_d;
      symbol_q <= symbol_d;
      error_q  <= error_d;
    end
  end

  // Valid pipeline tracks each sample through both stages; reset drops in-flight work
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_x_q <= 1'b0;
      vld_p_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      vld_x_q <= i_valid;
      vld_p_q <= vld_x_q;
      valid_q <= vld_p_q;
    end
  end

  assign o_valid  = valid_q;
  assign o_y      = y_q;
  assign o_symbol = symbol_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_ffe_slicer.sv
// Self-checking bench for ffe_slicer: directed identity/slicer/saturation cases,
// randomized back-to-back and gapped streams with changing taps, and mid-stream reset.
module tb_ffe_slicer;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_valid;
  logic signed [8:0]  i_data;
  logic [62:0]        i_coefs;
  logic               o_valid;
  logic signed [20:0] o_y;
  logic               o_symbol;
  logic signed [7:0]  o_error;

  int checks   = 0;
  int failures = 0;

  // Floor((8192 - 65025) / 128) for the saturation case
  localparam int SatErrFloor = -445;

  typedef struct {
    int         due;
    int         y;
    bit         sym;
    logic [7:0] err;
  } exp_t;

  exp_t       exp_q[$];
  int         dl[7];
  int         win[7];
  bit         win_pend;
  int         edge_n;
  int         last_y;
  bit         last_sym;
  logic [7:0] last_err;

  ffe_slicer u_dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_coefs  (i_coefs),
    .o_valid  (o_valid),
    .o_y      (o_y),
    .o_symbol (o_symbol),
    .o_error  (o_error)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] model_err(int y);
    int d;
    int e;
    d = (y >= 0) ? 8192 : -8192;
    e = (d - y) >>> 7;
`ifdef FFE_ERR_SAT_EN
    if (e > 127) return 8'h7F;
    if (e < -128) return 8'h80;
`endif
    return 8'(e);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 7; k++) dl[k] = 0;
    win_pend = 1'b0;
    exp_q.delete();
    last_y   = 0;
    last_sym = 1'b0;
    last_err = 8'h00;
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge
  task automatic tick();
    exp_t e;
    logic [62:0] cf;
    @(posedge i_clk);
    edge_n++;
    if (i_rst_n) begin
      if (win_pend) begin
        int s;
        s  = 0;
        cf = i_coefs;
        for (int k = 0; k < 7; k++) begin
          logic signed [8:0] cb;
          cb = cf[9*k +: 9];
          s += win[k] * int'(cb);
        end
        e.due = edge_n + 1;
        e.y   = s;
        e.sym = (s >= 0);
        e.err = model_err(s);
        exp_q.push_back(e);
      end
      win_pend = 1'b0;
      if (i_valid) begin
        for (int k = 6; k > 0; k--) dl[k] = dl[k-1];
        dl[0]    = int'(i_data);
        win      = dl;
        win_pend = 1'b1;
      end
    end
    @(negedge i_clk);
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      e = exp_q.pop_front();
      check("o_valid_hi", {31'b0, o_valid}, 32'd1);
      check("o_y", 32'(o_y), 32'(e.y));
      check("o_symbol", {31'b0, o_symbol}, {31'b0, e.sym});
      check("o_error", {24'b0, o_error}, {24'b0, e.err});
      last_y   = e.y;
      last_sym = e.sym;
      last_err = e.err;
    end else begin
      check("o_valid_lo", {31'b0, o_valid}, 32'd0);
      check("o_y_hold", 32'(o_y), 32'(last_y));
      check("o_symbol_hold", {31'b0, o_symbol}, {31'b0, last_sym});
      check("o_error_hold", {24'b0, o_error}, {24'b0, last_err});
    end
  endtask

  task automatic drive(input bit v, input logic [8:0] d);
    i_valid = v;
    i_data  = d;
    tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
    check({tag, "_y"}, 32'(o_y), 32'd0);
    check({tag, "_sym"}, {31'b0, o_symbol}, 32'd0);
    check({tag, "_err"}, {24'b0, o_error}, 32'd0);
  endtask

  initial begin
    logic [7:0] sat_exp;
    edge_n  = 0;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_coefs = '0;
    clear_model();
    #1;
    check_zero("reset_init");
    tick();
    tick();
    i_rst_n = 1'b1;

    // Identity: tap 3 = 1.0, impulse 0.5 appears on the 4th result
    i_coefs        = '0;
    i_coefs[35:27] = 9'h080;
    drive(1'b1, 9'h040);
    drive(1'b1, 9'h000);
    drive(1'b1, 9'h000);
    drive(1'b1, 9'h000);
    drive(1'b0, 9'h000);
    drive(1'b0, 9'h000);
    check("ident_y", 32'(o_y), 32'd8192);
    check("ident_sym", {31'b0, o_symbol}, 32'd1);
    check("ident_err", {24'b0, o_error}, 32'h00);

    // Slicer error at +0.75 and exact -0.5
    i_coefs       = '0;
    i_coefs[8:0]  = 9'h080;
    drive(1'b1, 9'h060);
    drive(1'b0, 9'h000);
    drive(1'b0, 9'h000);
    check("slice_pos_y", 32'(o_y), 32'd12288);
    check("slice_pos_sym", {31'b0, o_symbol}, 32'd1);
    check("slice_pos_err", {24'b0, o_error}, 32'hE0);
    drive(1'b1, 9'h1C0);
    drive(1'b0, 9'h000);
    drive(1'b0, 9'h000);
    check("slice_neg_y", 32'(o_y), 32'(-8192));
    check("slice_neg_sym", {31'b0, o_symbol}, 32'd0);
    check("slice_neg_err", {24'b0, o_error}, 32'h00);

    // Large positive output: error far below -128
`ifdef FFE_ERR_SAT_EN
    sat_exp = 8'h80;
`else
    sat_exp = 8'(SatErrFloor);
`endif
    i_coefs      = '0;
    i_coefs[8:0] = 9'h0FF;
    drive(1'b1, 9'h0FF);
    drive(1'b0, 9'h000);
    drive(1'b0, 9'h000);
    check("sat_y", 32'(o_y), 32'd65025);
    check("sat_sym", {31'b0, o_symbol}, 32'd1);
    check("sat_err", {24'b0, o_error}, {24'b0, sat_exp});

    // Back-to-back stream with taps changing every cycle
    for (int i = 0; i < 20; i++) begin
      i_coefs = 63'({$urandom(), $urandom()});
      drive(1'b1, 9'($urandom()));
    end

    // Gapped stream
    for (int i = 0; i < 15; i++) begin
      i_coefs = 63'({$urandom(), $urandom()});
      drive(1'b1, 9'($urandom()));
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        i_coefs = 63'({$urandom(), $urandom()});
        drive(1'b0, 9'($urandom()));
      end
    end

    // Mid-stream asynchronous reset with samples in flight
    for (int i = 0; i < 3; i++) begin
      i_coefs = 63'({$urandom(), $urandom()});
      drive(1'b1, 9'($urandom()));
    end
    #2 i_rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    clear_model();
    i_valid = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 9'h000);

    // First sample after reset must see empty taps 1..6
    i_coefs = 63'({$urandom(), $urandom()});
    drive(1'b1, 9'($urandom()));
    for (int i = 0; i < 3; i++) drive(1'b0, 9'h000);
    for (int i = 0; i < 8; i++) begin
      i_coefs = 63'({$urandom(), $urandom()});
      drive(1'($urandom_range(0, 1)), 9'($urandom()));
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 9'h000);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
